// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg
// Shared decode-stage definitions for the GPU ISA.
// Contents:
//   - opcode constants for the loop instructions
//   - default instruction address and iteration counter widths
//   - loop_entry_t, the default hardware loop stack entry {start, left}
package gpu_isa_pkg;

  localparam logic [7:0] OPC_LOOPCOUNT = 8'b11010001;
  localparam logic [7:0] OPC_STARTLOOP = 8'b11000000;
  localparam logic [7:0] OPC_ENDLOOP   = 8'b11001000;

  localparam int PC_WIDTH_DEF    = 16;
  localparam int COUNT_WIDTH_DEF = 16;

  // One open loop: where its body begins and how many passes remain,
  // counting the pass currently executing.
  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]    start;
    logic [COUNT_WIDTH_DEF-1:0] left;
  } loop_entry_t;

endpackage

// File: rtl/loop_stack.sv
// loop_stack
// LIFO of DEPTH loop entries with push, pop and in-place update of the top.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_push           write i_pushEntry above the current top (ignored when full)
//   i_pop            discard the top entry (ignored when empty)
//   i_update         overwrite the top entry with i_topEntry (ignored when empty)
//   o_top            current top entry, all zeros when empty
//   o_count          number of valid entries, 0..DEPTH
//   o_full, o_empty  occupancy flags
// The caller asserts at most one of push/pop/update per cycle; if several
// are asserted anyway, push wins over pop, and pop over update.
module loop_stack
  import gpu_isa_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type entry_t = loop_entry_t,
  parameter int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_update,
  input  entry_t           i_pushEntry,
  input  entry_t           i_topEntry,
  output entry_t           o_top,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  entry_t           r_entries [DEPTH];
  logic [CNT_W-1:0] r_count;
  entry_t           w_top;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Entry storage and occupancy. Popped slots are cleared so that the
  // stack contents always match their post-reset zeroed state above the top.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (i_push && !w_full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(r_count)) begin
          r_entries[i] <= i_pushEntry;
        end
      end
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !w_empty) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(r_count) - 1) begin
          r_entries[i] <= '0;
        end
      end
      r_count <= r_count - CNT_W'(1);
    end else if (i_update && !w_empty) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(r_count) - 1) begin
          r_entries[i] <= i_topEntry;
        end
      end
    end
  end

  // Top-of-stack read mux; reads as zero when nothing is open.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == int'(r_count) - 1) begin
        w_top = r_entries[i];
      end
    end
  end

  assign o_top   = w_top;
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/loop_ctrl.sv
// loop_ctrl
// Nested hardware loop controller for the GPU decode stage.
// Ports:
//   CLK, RESET       clock and synchronous active-high reset
//   Stall            freezes all state and outputs while high (RESET still acts)
//   PC               address of the instruction in decode
//   LoopCountValid   LOOPCOUNT strobe, LoopCount is its immediate
//   StartLoop        STARTLOOP strobe: open a loop whose body starts at PC+1
//   EndLoop          ENDLOOP strobe: branch back or close the innermost loop
//   Redirect         registered pulse telling fetch to jump to RedirectPC
//   RedirectPC       body start address of the loop branching back
//   Depth            number of open loops
//   IterLeft         remaining passes of the innermost loop (0 if none)
//   Overflow         sticky: STARTLOOP seen with every level in use
//   Underflow        sticky: ENDLOOP seen with no loop open
// Strobe priority is EndLoop > StartLoop > LoopCountValid, one per cycle.
module loop_ctrl
  import gpu_isa_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int DEPTH       = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       Stall,
  input  logic [PC_WIDTH-1:0]        PC,
  input  logic                       LoopCountValid,
  input  logic [COUNT_WIDTH-1:0]     LoopCount,
  input  logic                       StartLoop,
  input  logic                       EndLoop,
  output logic                       Redirect,
  output logic [PC_WIDTH-1:0]        RedirectPC,
  output logic [$clog2(DEPTH+1)-1:0] Depth,
  output logic [COUNT_WIDTH-1:0]     IterLeft,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Stack entry sized to this instance's widths.
  typedef struct packed {
    logic [PC_WIDTH-1:0]    start;
    logic [COUNT_WIDTH-1:0] left;
  } entry_t;

  logic [COUNT_WIDTH-1:0] r_pending;
  logic                   r_redirect;
  logic [PC_WIDTH-1:0]    r_redirectPC;
  logic                   r_overflow;
  logic                   r_underflow;

  logic             w_accept;
  logic             w_doEnd;
  logic             w_doStart;
  logic             w_doCount;
  logic             w_push;
  logic             w_pop;
  logic             w_update;
  logic             w_full;
  logic             w_empty;
  logic             w_branchBack;
  logic [CNT_W-1:0] w_count;
  entry_t           w_top;
  entry_t           w_pushEntry;
  entry_t           w_topEntry;

  // Strobe decode with priority; nothing is acted on during a stall.
  assign w_accept  = !Stall;
  assign w_doEnd   = w_accept && EndLoop;
  assign w_doStart = w_accept && StartLoop && !EndLoop;
  assign w_doCount = w_accept && LoopCountValid && !StartLoop && !EndLoop;

  // An ENDLOOP branches back while more than one pass remains; on the last
  // pass it closes the loop and falls through.
  assign w_branchBack = (w_top.left > COUNT_WIDTH'(1));
  assign w_push   = w_doStart && !w_full;
  assign w_update = w_doEnd && !w_empty && w_branchBack;
  assign w_pop    = w_doEnd && !w_empty && !w_branchBack;

  assign w_pushEntry.start = PC + PC_WIDTH'(1);
  assign w_pushEntry.left  = r_pending;
  assign w_topEntry.start  = w_top.start;
  assign w_topEntry.left   = w_top.left - COUNT_WIDTH'(1);

  loop_stack #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .CNT_W   (CNT_W)
  ) u_stack (
    .i_clk       (CLK),
    .i_reset     (RESET),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_update    (w_update),
    .i_pushEntry (w_pushEntry),
    .i_topEntry  (w_topEntry),
    .o_top       (w_top),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Pending count for the next STARTLOOP. A zero count still means one
  // pass, and each successful push consumes the pending value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending <= COUNT_WIDTH'(1);
    end else if (w_doCount) begin
      r_pending <= (LoopCount == '0) ? COUNT_WIDTH'(1) : LoopCount;
    end else if (w_push) begin
      r_pending <= COUNT_WIDTH'(1);
    end
  end

  // Redirect pulse. It is only re-evaluated on accepted cycles, so a
  // redirect raised just before a stall stays visible until fetch moves on.
  // RedirectPC keeps the last target between redirects.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_redirect   <= 1'b0;
      r_redirectPC <= '0;
    end else if (w_accept) begin
      r_redirect <= w_update;
      if (w_update) begin
        r_redirectPC <= w_top.start;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_doStart && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_doEnd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign Redirect   = r_redirect;
  assign RedirectPC = r_redirectPC;
  assign Depth      = w_count;
  assign IterLeft   = w_empty ? '0 : w_top.left;
  assign Overflow   = r_overflow;
  assign Underflow  = r_underflow;

endmodule

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl
// Self-checking bench for loop_ctrl with the default widths and DEPTH=4.
// The reference model keeps open loops in a queue and applies the
// instruction rules directly each accepted cycle.
module tb_loop_ctrl;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Stall;
  logic [15:0] PC;
  logic        LoopCountValid;
  logic [15:0] LoopCount;
  logic        StartLoop;
  logic        EndLoop;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic [2:0]  Depth;
  logic [15:0] IterLeft;
  logic        Overflow;
  logic        Underflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int start;
    int left;
  } ent_t;

  ent_t mStack[$];
  int   mPending;
  bit   mRedirect;
  int   mRpc;
  bit   mOverflow;
  bit   mUnderflow;

  loop_ctrl #(.PC_WIDTH(16), .COUNT_WIDTH(16), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .Stall          (Stall),
    .PC             (PC),
    .LoopCountValid (LoopCountValid),
    .LoopCount      (LoopCount),
    .StartLoop      (StartLoop),
    .EndLoop        (EndLoop),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .Depth          (Depth),
    .IterLeft       (IterLeft),
    .Overflow       (Overflow),
    .Underflow      (Underflow)
  );

  always #5 CLK = ~CLK;

  function automatic int mIter();
    return (mStack.size() == 0) ? 0 : mStack[$].left;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model and
  // leave time 1 unit after the edge so outputs can be sampled.
  task automatic step(input bit rst, input bit stl, input bit lcv,
                      input int lc, input bit sl, input bit el, input int pc);
    ent_t e;
    RESET = rst; Stall = stl; LoopCountValid = lcv; LoopCount = 16'(lc);
    StartLoop = sl; EndLoop = el; PC = 16'(pc);
    @(posedge CLK);
    if (rst) begin
      mStack.delete();
      mPending = 1; mRedirect = 0; mRpc = 0; mOverflow = 0; mUnderflow = 0;
    end else if (!stl) begin
      mRedirect = 0;
      if (el) begin
        if (mStack.size() == 0) mUnderflow = 1;
        else if (mStack[$].left > 1) begin
          e = mStack.pop_back();
          e.left = e.left - 1;
          mStack.push_back(e);
          mRedirect = 1;
          mRpc = e.start;
        end else begin
          void'(mStack.pop_back());
        end
      end else if (sl) begin
        if (mStack.size() == DEPTH) mOverflow = 1;
        else begin
          e.start = (pc + 1) % 65536;
          e.left = mPending;
          mStack.push_back(e);
          mPending = 1;
        end
      end else if (lcv) begin
        mPending = (lc % 65536 == 0) ? 1 : lc % 65536;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5, 1, 1, 3);
    tests++; if (Depth !== 3'd0) begin fails++; $display("[TB] FAIL reset_depth: got %0d want 0", Depth); end
    tests++; if (IterLeft !== 16'd0) begin fails++; $display("[TB] FAIL reset_iter: got %0d want 0", IterLeft); end
    tests++; if (Redirect !== 1'b0) begin fails++; $display("[TB] FAIL reset_redirect: got %0b want 0", Redirect); end
    tests++; if (RedirectPC !== 16'h0) begin fails++; $display("[TB] FAIL reset_rpc: got %0h want 0", RedirectPC); end
    tests++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags: got %0b%0b want 00", Overflow, Underflow); end
  endtask

  task automatic test_basic_loop();
    bit expRed [3] = '{1, 1, 0};
    int expIter [3] = '{2, 1, 0};
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 'h0F);
    step(0, 0, 0, 0, 1, 0, 'h10);
    tests++; if (IterLeft !== 16'd3 || Depth !== 3'd1) begin fails++; $display("[TB] FAIL basic_start: got iter %0d depth %0d want 3 1", IterLeft, Depth); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, 'h11 + i);
      tests++; if (Redirect !== expRed[i]) begin fails++; $display("[TB] FAIL basic_redirect%0d: got %0b want %0b", i, Redirect, expRed[i]); end
      tests++; if (IterLeft !== 16'(expIter[i])) begin fails++; $display("[TB] FAIL basic_iter%0d: got %0d want %0d", i, IterLeft, expIter[i]); end
      if (expRed[i]) begin
        tests++; if (RedirectPC !== 16'h11) begin fails++; $display("[TB] FAIL basic_rpc%0d: got %0h want 11", i, RedirectPC); end
      end
    end
    tests++; if (Depth !== 3'd0) begin fails++; $display("[TB] FAIL basic_depth_end: got %0d want 0", Depth); end
  endtask

  task automatic test_nested();
    int pc = 'h1F;
    int steps = 0;
    int toInner = 0;
    int toOuter = 0;
    int peak = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    while (pc <= 'h25 && steps < 40) begin
      step(0, 0, (pc == 'h1F || pc == 'h21), 2, (pc == 'h20 || pc == 'h22),
           (pc == 'h24 || pc == 'h25), pc);
      if (Redirect === 1'b1 && RedirectPC === 16'h23) toInner++;
      if (Redirect === 1'b1 && RedirectPC === 16'h21) toOuter++;
      if (int'(Depth) > peak) peak = int'(Depth);
      pc = mRedirect ? mRpc : pc + 1;
      steps++;
    end
    tests++; if (steps >= 40) begin fails++; $display("[TB] FAIL nested_timeout: got %0d steps want <40", steps); end
    tests++; if (toInner !== 2) begin fails++; $display("[TB] FAIL nested_inner_redirects: got %0d want 2", toInner); end
    tests++; if (toOuter !== 1) begin fails++; $display("[TB] FAIL nested_outer_redirects: got %0d want 1", toOuter); end
    tests++; if (peak !== 2) begin fails++; $display("[TB] FAIL nested_peak_depth: got %0d want 2", peak); end
    tests++; if (Depth !== 3'd0) begin fails++; $display("[TB] FAIL nested_end_depth: got %0d want 0", Depth); end
  endtask

  task automatic test_count_edge();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 'h40);
    step(0, 0, 0, 0, 1, 0, 'h41);
    tests++; if (IterLeft !== 16'd1) begin fails++; $display("[TB] FAIL count0_iter: got %0d want 1", IterLeft); end
    step(0, 0, 0, 0, 0, 1, 'h42);
    tests++; if (Redirect !== 1'b0 || Depth !== 3'd0) begin fails++; $display("[TB] FAIL count0_end: got red %0b depth %0d want 0 0", Redirect, Depth); end
    step(0, 0, 0, 0, 1, 0, 'h50);
    tests++; if (IterLeft !== 16'd1) begin fails++; $display("[TB] FAIL nocount_iter: got %0d want 1", IterLeft); end
    step(0, 0, 0, 0, 0, 1, 'h51);
    tests++; if (Redirect !== 1'b0 || Depth !== 3'd0) begin fails++; $display("[TB] FAIL nocount_end: got red %0b depth %0d want 0 0", Redirect, Depth); end
  endtask

  task automatic test_limits();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, i + 2, 0, 0, 'h60 + 2 * i);
      step(0, 0, 0, 0, 1, 0, 'h61 + 2 * i);
    end
    tests++; if (Depth !== 3'd4 || Overflow !== 1'b0) begin fails++; $display("[TB] FAIL limit_full: got depth %0d ovf %0b want 4 0", Depth, Overflow); end
    tests++; if (IterLeft !== 16'd5) begin fails++; $display("[TB] FAIL limit_top_iter: got %0d want 5", IterLeft); end
    step(0, 0, 0, 0, 1, 0, 'h70);
    tests++; if (Depth !== 3'd4 || Overflow !== 1'b1) begin fails++; $display("[TB] FAIL limit_overflow: got depth %0d ovf %0b want 4 1", Depth, Overflow); end
    tests++; if (IterLeft !== 16'd5) begin fails++; $display("[TB] FAIL limit_ovf_iter: got %0d want 5", IterLeft); end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 'h71);
    tests++; if (Overflow !== 1'b1) begin fails++; $display("[TB] FAIL limit_ovf_sticky: got %0b want 1", Overflow); end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 'h80);
    tests++; if (Underflow !== 1'b1 || Depth !== 3'd0) begin fails++; $display("[TB] FAIL limit_underflow: got unf %0b depth %0d want 1 0", Underflow, Depth); end
    step(0, 0, 1, 2, 0, 0, 'h81);
    step(0, 0, 0, 0, 1, 0, 'h82);
    idle();
    tests++; if (Underflow !== 1'b1 || Overflow !== 1'b0) begin fails++; $display("[TB] FAIL limit_unf_sticky: got unf %0b ovf %0b want 1 0", Underflow, Overflow); end
  endtask

  task automatic test_stall_priority();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 'h90);
    step(0, 0, 0, 0, 1, 0, 'h91);
    step(0, 0, 0, 0, 0, 1, 'h93);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 9, 0, 1, 'h94);
      tests++; if (Redirect !== 1'b1 || IterLeft !== 16'd2) begin fails++; $display("[TB] FAIL stall_hold%0d: got red %0b iter %0d want 1 2", i, Redirect, IterLeft); end
    end
    idle();
    tests++; if (Redirect !== 1'b0) begin fails++; $display("[TB] FAIL stall_release: got %0b want 0", Redirect); end
    step(0, 0, 1, 7, 1, 1, 'hA0);
    tests++; if (Redirect !== 1'b1 || Depth !== 3'd1 || IterLeft !== 16'd1) begin fails++; $display("[TB] FAIL prio_end_wins: got red %0b depth %0d iter %0d want 1 1 1", Redirect, Depth, IterLeft); end
    step(0, 0, 0, 0, 1, 0, 'hA1);
    tests++; if (Depth !== 3'd2 || IterLeft !== 16'd1) begin fails++; $display("[TB] FAIL prio_count_dropped: got depth %0d iter %0d want 2 1", Depth, IterLeft); end
    step(0, 0, 0, 0, 0, 1, 'hA5);
    step(0, 0, 0, 0, 0, 1, 'hA6);
    tests++; if (Depth !== 3'd0) begin fails++; $display("[TB] FAIL prio_drain: got %0d want 0", Depth); end
  endtask

  task automatic test_reset_mid_loop();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0, 'hB0);
    step(0, 0, 0, 0, 1, 0, 'hB1);
    step(0, 0, 1, 2, 0, 0, 'hB2);
    step(0, 0, 0, 0, 1, 0, 'hB3);
    step(0, 0, 1, 6, 0, 0, 'hB4);
    step(0, 0, 0, 0, 0, 1, 'hB5);
    tests++; if (Depth !== 3'd2 || Redirect !== 1'b1) begin fails++; $display("[TB] FAIL midrst_setup: got depth %0d red %0b want 2 1", Depth, Redirect); end
    step(1, 1, 0, 0, 0, 0, 0);
    tests++; if (Depth !== 3'd0 || Redirect !== 1'b0) begin fails++; $display("[TB] FAIL midrst_clear: got depth %0d red %0b want 0 0", Depth, Redirect); end
    step(0, 0, 0, 0, 1, 0, 'hC0);
    tests++; if (IterLeft !== 16'd1) begin fails++; $display("[TB] FAIL midrst_pending: got %0d want 1", IterLeft); end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 35), int'($urandom_range(0, 4)),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 35),
           int'($urandom_range(0, 65535)));
      tests++; if (Redirect !== mRedirect) begin fails++; $display("[TB] FAIL rand_redirect@%0d: got %0b want %0b", n, Redirect, mRedirect); end
      tests++; if (RedirectPC !== 16'(mRpc)) begin fails++; $display("[TB] FAIL rand_rpc@%0d: got %0h want %0h", n, RedirectPC, mRpc); end
      tests++; if (int'(Depth) !== mStack.size()) begin fails++; $display("[TB] FAIL rand_depth@%0d: got %0d want %0d", n, Depth, mStack.size()); end
      tests++; if (int'(IterLeft) !== mIter()) begin fails++; $display("[TB] FAIL rand_iter@%0d: got %0d want %0d", n, IterLeft, mIter()); end
      tests++; if (Overflow !== mOverflow || Underflow !== mUnderflow) begin fails++; $display("[TB] FAIL rand_flags@%0d: got %0b%0b want %0b%0b", n, Overflow, Underflow, mOverflow, mUnderflow); end
    end
  endtask

  initial begin
    mPending = 1; mRedirect = 0; mRpc = 0; mOverflow = 0; mUnderflow = 0;
    test_reset();
    test_basic_loop();
    test_nested();
    test_count_edge();
    test_limits();
    test_stall_priority();
    test_reset_mid_loop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
